// File: rtl/myaccip_s00_axi_regs.sv
// AXI4-Lite slave register file for the myaccip S00_AXI port; MYACCIP_S00_REG_SLVERR_EN turns out-of-range responses into SLVERR.
// Latency: BVALID/RVALID and reg_wr_pulse one cycle after the completing handshake.
// Backpressure: one write and one read outstanding; the channel readies stay low until the B/R handshake.
module myaccip_s00_axi_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int NUM_REGS           = 4
) (
    input  logic                                   ACLK,
    input  logic                                   ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_out,
    output logic [NUM_REGS-1:0]                    reg_wr_pulse
);

    localparam int IDXW  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STRBW = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef MYACCIP_S00_REG_SLVERR_EN
    localparam logic [1:0] RESP_OOR = 2'b10;
`else
    localparam logic [1:0] RESP_OOR = 2'b00;
`endif

    typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_DATA} r_state_e;

    w_state_e                                  w_state_q, w_state_d;
    r_state_e                                  r_state_q, r_state_d;
    logic                                      awready_q, wready_q, bvalid_q;
    logic                                      arready_q, rvalid_q;
    logic [1:0]                                bresp_q, rresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]             rdata_q;
    logic [IDXW-1:0]                           waddr_q;
    logic [C_S_AXI_DATA_WIDTH-1:0]             wdata_q;
    logic [STRBW-1:0]                          wstrb_q;
    logic [NUM_REGS-1:0]                       pulse_q, pulse_d;
    logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs_q;

    logic                                      aw_hs, w_hs, ar_hs, wr_commit;
    logic [IDXW-1:0]                           aw_idx, ar_idx, wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]             wr_dat, rd_val;
    logic [STRBW-1:0]                          wr_strb;

    function automatic logic idx_ok(input logic [IDXW-1:0] idx);
        return 32'(idx) < 32'(NUM_REGS);
    endfunction

    assign aw_idx = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
    assign aw_hs  = S_AXI_AWVALID && awready_q;
    assign w_hs   = S_AXI_WVALID && wready_q;
    assign ar_hs  = S_AXI_ARVALID && arready_q;

    // Byte-lane bits are don't-care and PROT carries no meaning for this block.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    always_comb begin
        w_state_d = w_state_q;
        wr_commit = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_d = W_RESP;
                    wr_commit = 1'b1;
                end else if (aw_hs) begin
                    w_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs) begin
                    w_state_d = W_RESP;
                    wr_commit = 1'b1;
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs) begin
                    w_state_d = W_RESP;
                    wr_commit = 1'b1;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Whichever half arrived first comes from the latch; the other is live on the bus.
    always_comb begin
        wr_idx  = (w_state_q == W_HAVE_ADDR) ? waddr_q : aw_idx;
        wr_dat  = (w_state_q == W_HAVE_DATA) ? wdata_q : S_AXI_WDATA;
        wr_strb = (w_state_q == W_HAVE_DATA) ? wstrb_q : S_AXI_WSTRB;
        pulse_d = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            pulse_d[k] = wr_commit && (wr_idx == IDXW'(k));
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            pulse_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
            wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
            bvalid_q  <= (w_state_d == W_RESP);
            pulse_q   <= pulse_d;
            if ((w_state_q == W_IDLE) && aw_hs) waddr_q <= aw_idx;
            if ((w_state_q == W_IDLE) && w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (wr_commit) bresp_q <= idx_ok(wr_idx) ? RESP_OKAY : RESP_OOR;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                for (int b = 0; b < STRBW; b++) begin
                    if (pulse_d[k] && wr_strb[b]) regs_q[k][8*b +: 8] <= wr_dat[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_val = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (ar_idx == IDXW'(k)) rd_val = regs_q[k];
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // rd_val samples regs_q before any same-edge write lands, so reads see the old value.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_DATA);
            if (ar_hs) begin
                rdata_q <= rd_val;
                rresp_q <= idx_ok(ar_idx) ? RESP_OKAY : RESP_OOR;
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign regs_out      = regs_q;
    assign reg_wr_pulse  = pulse_q;

endmodule

// File: tb/tb_myaccip_s00_axi_regs.sv
// Directed bench for myaccip_s00_axi_regs, built with a 5-bit address so index 4 and up is out of range.
module tb_myaccip_s00_axi_regs;

    localparam int AW = 5;
    localparam int NR = 4;
`ifdef MYACCIP_S00_REG_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic           ACLK = 1'b0;
    logic           ARESETN;
    logic [AW-1:0]  S_AXI_AWADDR, S_AXI_ARADDR;
    logic [2:0]     S_AXI_AWPROT, S_AXI_ARPROT;
    logic           S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
    logic [31:0]    S_AXI_WDATA, S_AXI_RDATA;
    logic [3:0]     S_AXI_WSTRB;
    logic [1:0]     S_AXI_BRESP, S_AXI_RRESP;
    logic           S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
    logic           S_AXI_RVALID, S_AXI_RREADY;
    logic [NR*32-1:0] regs_out;
    logic [NR-1:0]  reg_wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [1:0]  resp;
    logic [3:0]  pulse;
    logic [31:0] rdata;

    myaccip_s00_axi_regs #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(NR)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .regs_out(regs_out), .reg_wr_pulse(reg_wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_hold,
                             output logic [1:0] r, output logic [3:0] p);
        bit aw_done, w_done, aw_hs, w_hs, early_b, stable;
        int n;
        aw_done = 0; w_done = 0; early_b = 0; stable = 1; n = 0;
        @(posedge ACLK); #1;
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
        while (!(aw_done && w_done) && n < 40) begin
            S_AXI_AWVALID = !aw_done && (n >= aw_dly);
            S_AXI_WVALID  = !w_done && (n >= w_dly);
            @(negedge ACLK);
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            if (S_AXI_BVALID) early_b = 1;
            @(posedge ACLK); #1;
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            n++;
        end
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        chk("wr_handshake", 128'(aw_done && w_done), 128'(1));
        chk("wr_no_early_bvalid", 128'(early_b), 128'(0));
        @(negedge ACLK);
        chk("wr_bvalid", 128'(S_AXI_BVALID), 128'(1));
        r = S_AXI_BRESP; p = reg_wr_pulse;
        for (int i = 0; i < b_hold; i++) begin
            @(negedge ACLK);
            if (!(S_AXI_BVALID && S_AXI_BRESP == r && !S_AXI_AWREADY && !S_AXI_WREADY && reg_wr_pulse == 0))
                stable = 0;
        end
        if (b_hold > 0) chk("wr_hold_stable", 128'(stable), 128'(1));
        S_AXI_BREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0;
        @(negedge ACLK);
        chk("wr_bvalid_dropped", 128'(S_AXI_BVALID), 128'(0));
        chk("wr_pulse_one_cycle", 128'(reg_wr_pulse), 128'(0));
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int r_hold,
                            output logic [31:0] d, output logic [1:0] r);
        bit done, stable;
        int n;
        done = 0; stable = 1; n = 0;
        @(posedge ACLK); #1;
        S_AXI_ARADDR = addr;
        while (!done && n < 40) begin
            S_AXI_ARVALID = 1;
            @(negedge ACLK);
            done = S_AXI_ARREADY;
            @(posedge ACLK); #1;
            n++;
        end
        S_AXI_ARVALID = 0;
        chk("rd_handshake", 128'(done), 128'(1));
        @(negedge ACLK);
        chk("rd_rvalid", 128'(S_AXI_RVALID), 128'(1));
        d = S_AXI_RDATA; r = S_AXI_RRESP;
        for (int i = 0; i < r_hold; i++) begin
            @(negedge ACLK);
            if (!(S_AXI_RVALID && S_AXI_RDATA == d && S_AXI_RRESP == r && !S_AXI_ARREADY)) stable = 0;
        end
        if (r_hold > 0) chk("rd_hold_stable", 128'(stable), 128'(1));
        S_AXI_RREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_RREADY = 0;
        @(negedge ACLK);
        chk("rd_rvalid_dropped", 128'(S_AXI_RVALID), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before the sequence ended");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 0;
        S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 0;
        S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
        S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;

        // Reset state
        repeat (3) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
        chk("rst_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b00));
        chk("rst_resp_data", 128'({S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}), 128'(0));
        chk("rst_regs", regs_out, 128'(0));
        chk("rst_pulse", 128'(reg_wr_pulse), 128'(0));
        ARESETN = 1;
        #1;
        chk("release_readies_low", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
        @(posedge ACLK); #1;
        chk("first_edge_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));

        // Basic write and read-back of all four registers
        for (int k = 0; k < 4; k++) begin
            axi_write(5'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0, resp, pulse);
            chk($sformatf("wr%0d_bresp", k), 128'(resp), 128'(2'b00));
            chk($sformatf("wr%0d_pulse", k), 128'(pulse), 128'(4'b0001 << k));
        end
        chk("regs_after_basic", regs_out, {32'h4, 32'h3, 32'h2, 32'h1});
        for (int k = 0; k < 4; k++) begin
            axi_read(5'(4 * k), 0, rdata, resp);
            chk($sformatf("rd%0d_data", k), 128'(rdata), 128'(k + 1));
            chk($sformatf("rd%0d_rresp", k), 128'(resp), 128'(2'b00));
        end

        // AW leads W by 3 cycles, then W leads AW
        axi_write(5'h00, 32'h55, 4'hF, 0, 3, 0, resp, pulse);
        chk("aw_first_pulse", 128'(pulse), 128'(4'b0001));
        axi_write(5'h04, 32'h66, 4'hF, 3, 0, 0, resp, pulse);
        chk("w_first_pulse", 128'(pulse), 128'(4'b0010));
        chk("regs_after_split", regs_out, {32'h4, 32'h3, 32'h66, 32'h55});

        // Byte strobes
        axi_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0, resp, pulse);
        axi_write(5'h04, 32'h11223344, 4'h5, 0, 0, 0, resp, pulse);
        axi_read(5'h04, 0, rdata, resp);
        chk("strb5_data", 128'(rdata), 128'(32'hAA22CC44));
        axi_write(5'h04, 32'hFFFFFFFF, 4'h0, 0, 0, 0, resp, pulse);
        chk("strb0_pulse", 128'(pulse), 128'(4'b0010));
        chk("strb0_bresp", 128'(resp), 128'(2'b00));
        axi_read(5'h07, 0, rdata, resp);
        chk("strb0_unaligned_data", 128'(rdata), 128'(32'hAA22CC44));

        // Response backpressure for 10 cycles, unaligned write address
        axi_write(5'h0D, 32'h12345678, 4'hF, 0, 0, 10, resp, pulse);
        chk("hold_pulse", 128'(pulse), 128'(4'b1000));
        axi_read(5'h0C, 10, rdata, resp);
        chk("hold_rdata", 128'(rdata), 128'(32'h12345678));

        // Same-edge write and read of reg2
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 5'h08; S_AXI_WDATA = 32'hDEAD; S_AXI_WSTRB = 4'hF; S_AXI_ARADDR = 5'h08;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
        @(negedge ACLK);
        chk("same_edge_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_ARVALID = 0;
        @(negedge ACLK);
        chk("same_edge_valids", 128'({S_AXI_BVALID, S_AXI_RVALID}), 128'(2'b11));
        chk("same_edge_old_data", 128'(S_AXI_RDATA), 128'(32'h3));
        chk("same_edge_pulse", 128'(reg_wr_pulse), 128'(4'b0100));
        S_AXI_BREADY = 1; S_AXI_RREADY = 1;
        @(posedge ACLK); #1;
        S_AXI_BREADY = 0; S_AXI_RREADY = 0;
        axi_read(5'h08, 0, rdata, resp);
        chk("same_edge_new_data", 128'(rdata), 128'(32'hDEAD));

        // Out-of-range index
        axi_write(5'h10, 32'hCAFE, 4'hF, 0, 0, 0, resp, pulse);
        chk("oor_bresp", 128'(resp), 128'(EXP_OOR));
        chk("oor_pulse", 128'(pulse), 128'(4'b0000));
        chk("oor_regs", regs_out, {32'h12345678, 32'hDEAD, 32'hAA22CC44, 32'h55});
        axi_read(5'h10, 0, rdata, resp);
        chk("oor_rdata", 128'(rdata), 128'(0));
        chk("oor_rresp", 128'(resp), 128'(EXP_OOR));
        axi_read(5'h1C, 0, rdata, resp);
        chk("oor_top_rdata", 128'(rdata), 128'(0));

        // Reset while the write response is pending
        @(posedge ACLK); #1;
        S_AXI_AWADDR = 5'h00; S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
        @(posedge ACLK); #1;
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        @(negedge ACLK);
        chk("pre_rst_bvalid", 128'(S_AXI_BVALID), 128'(1));
        chk("pre_rst_reg0", 128'(regs_out[31:0]), 128'(32'h77));
        #2 ARESETN = 0;
        #1;
        chk("mid_rst_bvalid", 128'(S_AXI_BVALID), 128'(0));
        chk("mid_rst_regs", regs_out, 128'(0));
        chk("mid_rst_readies", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
        chk("mid_rst_pulse", 128'(reg_wr_pulse), 128'(0));
        @(negedge ACLK);
        ARESETN = 1;
        #1;
        chk("post_rst_readies_low", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b000));
        @(posedge ACLK); #1;
        chk("post_rst_readies_high", 128'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 128'(3'b111));
        axi_read(5'h00, 0, rdata, resp);
        chk("post_rst_reg0", 128'(rdata), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/myaccip_s00_axi_regs.md
Name: myaccip_s00_axi_regs

Overview:
- AXI4-Lite slave register file behind the myaccip S00_AXI port; it is the responder to the master VIP / PS-side initiator.
- Accepts single-beat writes and reads into NUM_REGS 32-bit registers with byte strobes and returns OKAY (or SLVERR, optional) responses.
- Exposes register contents and per-register write pulses to the accelerator core.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; the register index is ADDR[C_S_AXI_ADDR_WIDTH-1:2].
- NUM_REGS, 4, number of implemented registers; must be ≤ 2^(C_S_AXI_ADDR_WIDTH-2).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte enables.
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write data handshake.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read data handshake.
- regs_out  out  NUM_REGS*32  register contents; reg k occupies bits [32k+31:32k].
- reg_wr_pulse  out  NUM_REGS  one-cycle pulse on bit k, one cycle after reg k is written.

Behaviour:
- Reset:
  - All registers are 0.
  - AWREADY, WREADY, ARREADY, BVALID, RVALID and reg_wr_pulse are 0.
  - BRESP, RRESP and RDATA are 0.
  - Both FSMs go to IDLE.
- Ready gating: the ready outputs are registered. They rise on the first ACLK edge with ARESETN high and never combinationally depend on VALID inputs.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP.
  - AWREADY = 1 in W_IDLE and W_HAVE_DATA.
  - WREADY = 1 in W_IDLE and W_HAVE_ADDR.
  - W_IDLE with both AW and W handshakes in the same cycle: go directly to W_RESP.
  - AW handshake only: latch AWADDR, go to W_HAVE_ADDR.
  - W handshake only: latch WDATA and WSTRB, go to W_HAVE_DATA.
  - Completing handshake: register update happens on the same edge; BVALID = 1 and reg_wr_pulse[k] = 1 on the next cycle (state W_RESP). All readies are 0 in W_RESP.
  - BVALID and BRESP hold until BREADY; the BVALID && BREADY edge returns to W_IDLE.
- Strobes: byte b of the target register updates only when WSTRB[b] = 1. WSTRB = 0 leaves the register unchanged but still yields a response and a pulse.
- Read FSM states: R_IDLE, R_DATA.
  - ARREADY = 1 only in R_IDLE.
  - On ARVALID handshake: RDATA is registered from the addressed register, RVALID = 1 next cycle.
  - RDATA, RRESP and RVALID hold stable until RREADY; then return to R_IDLE.
  - RDATA changes only on the AR handshake edge.
- Throughput: one outstanding write and one outstanding read. The write and read FSMs are fully independent.
- Same-edge read/write to the same register: the read returns the pre-write value.
- Address bits [1:0] are ignored (unaligned addresses are treated as aligned).
- Out-of-range index (≥ NUM_REGS):
  - Writes are dropped and no pulse is generated.
  - Reads return 0.
  - Response code depends on the optional feature.
- Reset mid-transaction: FSMs return to IDLE immediately, all VALID outputs drop asynchronously, registers clear, and the pending transaction is lost.

Optional Feature:
- MYACCIP_S00_REG_SLVERR_EN
- Defined: out-of-range writes return BRESP = 2'b10 (SLVERR) and out-of-range reads return RRESP = 2'b10.
- Undefined: all responses are OKAY (2'b00); out-of-range behaviour is otherwise identical (write dropped, read data 0).

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to 0x0/0x4/0x8/0xC (WSTRB = 0xF), then read back the same addresses -> RDATA = 0x1, 0x2, 0x3, 0x4; all responses 2'b00; reg_wr_pulse = 0001, 0010, 0100, 1000 in order.
- AWVALID 3 cycles before WVALID (and then reversed) -> single BVALID after the later handshake; register updated exactly once.
- Reg1 = 0xAABBCCDD, then write 0x11223344 with WSTRB = 0x5 -> reg1 = 0xAA22CC44.
- Hold BREADY/RREADY low for 10 cycles -> BVALID/RVALID, BRESP and RDATA stable; AWREADY/WREADY/ARREADY stay 0 until the response handshake.
- Simultaneous write 0xDEAD to reg2 (old value 0x3) and read of reg2 -> read returns 0x3; a subsequent read returns 0xDEAD.
- C_S_AXI_ADDR_WIDTH = 5, write/read at 0x10:
  - With MYACCIP_S00_REG_SLVERR_EN: BRESP = RRESP = 2'b10, RDATA = 0, no pulse.
  - Without it: responses are 2'b00.
- Assert ARESETN low while in W_RESP -> BVALID = 0 immediately, registers = 0, readies = 0 until the first edge after release.
